// File: rtl/hall_decoder.sv
// Hall sensor decoder: synchronizes, debounces and validates a 3-bit hall code.
// It reports the sector, step pulses, direction, errors and stall. Define HALL_ERR_CNT_EN to build the error counter.
module hall_decoder #(
  parameter int DEBOUNCE_CYCLES = 50,
  parameter int STALL_CYCLES    = 3163477
) (
  input  logic       i_inclk,
  input  logic       i_rst_n,
  input  logic [2:0] i_h_raw,
  output logic [2:0] o_h_clean,
  output logic [2:0] o_sector,
  output logic       o_step,
  output logic       o_dir,
  output logic       o_hall_err,
  output logic       o_stalled,
  output logic [7:0] o_err_count
);

  localparam logic [7:0]  DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  DB_MAX    = 8'(DEBOUNCE_CYCLES);
  localparam logic [21:0] STALL_MAX = 22'(STALL_CYCLES);

  function automatic logic [2:0] sectorOf(input logic [2:0] code);
    logic [2:0] s;
    s = 3'd0;
    case (code)
      3'b001: s = 3'd0;
      3'b011: s = 3'd1;
      3'b010: s = 3'd2;
      3'b110: s = 3'd3;
      3'b100: s = 3'd4;
      3'b101: s = 3'd5;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  logic [2:0]  r_sync1;
  logic [2:0]  r_sync2;
  logic [2:0]  r_cand;
  logic [7:0]  r_stableCnt;
  logic [2:0]  r_hClean;
  logic [2:0]  r_sector;
  logic        r_step;
  logic        r_dir;
  logic        r_hallErr;
  logic        r_haveFirst;
  logic [21:0] r_stallCnt;

  logic        w_same;
  logic        w_event;
  logic        w_valid;
  logic [2:0]  w_newSector;
  logic [2:0]  w_nextSector;
  logic [2:0]  w_prevSector;
  logic        w_fwd;
  logic        w_rev;
  logic        w_stepNow;
  logic        w_errNow;

  // The accept event fires exactly once per stable entry: the cycle the counter crosses DB_LAST.
  assign w_same       = (r_sync2 == r_cand);
  assign w_event      = w_same && (r_stableCnt == DB_LAST) && (r_cand != r_hClean);
  assign w_valid      = (r_cand != 3'b000) && (r_cand != 3'b111);
  assign w_newSector  = sectorOf(r_cand);
  assign w_nextSector = (r_sector == 3'd5) ? 3'd0 : r_sector + 3'd1;
  assign w_prevSector = (r_sector == 3'd0) ? 3'd5 : r_sector - 3'd1;
  assign w_fwd        = w_event && w_valid && r_haveFirst && (w_newSector == w_nextSector);
  assign w_rev        = w_event && w_valid && r_haveFirst && (w_newSector == w_prevSector);
  assign w_stepNow    = w_fwd || w_rev;
  assign w_errNow     = w_event && (!w_valid || (r_haveFirst && !w_fwd && !w_rev));

  always_ff @(posedge i_inclk) begin
    if (!i_rst_n) begin
      r_sync1     <= 3'b000;
      r_sync2     <= 3'b000;
      r_cand      <= 3'b000;
      r_stableCnt <= 8'd0;
      r_hClean    <= 3'b000;
      r_sector    <= 3'd0;
      r_step      <= 1'b0;
      r_dir       <= 1'b1;
      r_hallErr   <= 1'b0;
      r_haveFirst <= 1'b0;
      r_stallCnt  <= 22'd0;
    end else begin
      r_sync1 <= i_h_raw;
      r_sync2 <= r_sync1;

      if (!w_same) begin
        r_cand      <= r_sync2;
        r_stableCnt <= 8'd0;
      end else if (r_stableCnt != DB_MAX) begin
        r_stableCnt <= r_stableCnt + 8'd1;
      end

      // Invalid codes only raise an error; h_clean, sector and dir keep their last valid values.
      if (w_event && w_valid) begin
        r_hClean    <= r_cand;
        r_sector    <= w_newSector;
        r_haveFirst <= 1'b1;
      end
      if (w_fwd) begin
        r_dir <= 1'b1;
      end else if (w_rev) begin
        r_dir <= 1'b0;
      end
      r_step    <= w_stepNow;
      r_hallErr <= w_errNow;

      if (w_stepNow) begin
        r_stallCnt <= 22'd0;
      end else if (r_stallCnt != STALL_MAX) begin
        r_stallCnt <= r_stallCnt + 22'd1;
      end
    end
  end

`ifdef HALL_ERR_CNT_EN
  logic [7:0] r_errCount;

  always_ff @(posedge i_inclk) begin
    if (!i_rst_n) begin
      r_errCount <= 8'd0;
    end else if (w_errNow && (r_errCount != 8'hFF)) begin
      r_errCount <= r_errCount + 8'd1;
    end
  end

  assign o_err_count = r_errCount;
`else
  assign o_err_count = 8'd0;
`endif

  assign o_h_clean  = r_hClean;
  assign o_sector   = r_sector;
  assign o_step     = r_step;
  assign o_dir      = r_dir;
  assign o_hall_err = r_hallErr;
  assign o_stalled  = (r_stallCnt == STALL_MAX);

endmodule
